lc3_mem_responder: RTL and testbench

// - Synthesizable, parametrised instruction + data memory responder for the LC3 pipeline core.
// - Serves the core's instrmem_rd/pc and Data_rd/Data_wr/Data_addr requests from internal arrays.
// - Each port has independent, programmable wait-state latency and a complete_* pulse handshake.
// - Sits between the core and the bench; replaces the per-cycle behavioural memory loop.

---
 rtl/lc3_mem_pkg.sv | 21 ++
 rtl/lc3_mem_port_fsm.sv | 96 +++++++++
 rtl/lc3_mem_responder.sv | 188 ++++++++++++++++++
 tb/tb_lc3_mem_responder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC3 instruction/data memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package lc3_mem_pkg;

    typedef logic [15:0] lc3_word_t;

    // Per-port request sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_st_e;

    localparam lc3_word_t LC3_BASE_ADDR = 16'h3000;
    localparam int        LAT_CNT_W     = 4;

    // Word returned by an out-of-range fetch when error reporting is built in.
    localparam lc3_word_t LC3_OOR_WORD  = 16'hDEAD;

endpackage

// File: rtl/lc3_mem_port_fsm.sv
// One request port sequencer: IDLE -> (WAIT x LAT) -> RESP -> IDLE, captures the address.
// Latency: o_complete is high in the (LAT+1)-th cycle after the edge that sampled i_req.
// Backpressure: requester holds i_req until o_complete; dropping it during WAIT aborts.
//
// Ports:
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   i_req          request level, held by the requester
//   i_addr         raw request address
//   o_addr         address for this transaction (raw while idle, captured afterwards)
//   o_complete     one-cycle completion pulse (RESP state)
//   o_fire         high in the cycle whose closing edge moves the port into RESP
//   o_idle         port is idle and will sample i_req on the next edge
module lc3_mem_port_fsm
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int LAT    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_complete,
    output logic              o_fire,
    output logic              o_idle
);

    mem_st_e                r_state;
    mem_st_e                w_next;
    logic [LAT_CNT_W-1:0]   r_cnt;
    logic [LAT_CNT_W-1:0]   w_cnt_next;
    logic [ADDR_W-1:0]      r_addr;

    // Load value for the wait counter; only meaningful when LAT > 0.
    localparam logic [LAT_CNT_W-1:0] CNT_LOAD = (LAT == 0) ? '0 : LAT_CNT_W'(LAT - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (r_state == IDLE && i_req) begin
                r_addr <= i_addr;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        o_fire     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_req) begin
                    if (LAT == 0) begin
                        w_next = RESP;
                        o_fire = 1'b1;
                    end else begin
                        w_next     = WAIT;
                        w_cnt_next = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (!i_req) begin
                    // Requester withdrew: abandon without completing.
                    w_next     = IDLE;
                    w_cnt_next = '0;
                end else if (r_cnt == '0) begin
                    w_next = RESP;
                    o_fire = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            RESP: begin
                // Always pass through IDLE so a held request is re-sampled as a new one.
                w_next = IDLE;
            end
            default: begin
                w_next     = IDLE;
                w_cnt_next = '0;
            end
        endcase
    end

    // With LAT=0 the transaction fires in the sampling cycle, before r_addr is loaded.
    assign o_addr     = (r_state == IDLE) ? i_addr : r_addr;
    assign o_complete = (r_state == RESP);
    assign o_idle     = (r_state == IDLE);

endmodule

// File: rtl/lc3_mem_responder.sv
// Instruction + data memory responder for the LC3 core, with independent wait states per port.
// Latency: complete_instr / complete_data pulse IMEM_LAT+1 / DMEM_LAT+1 cycles after sampling.
// Backpressure: requests are held until complete_*; one outstanding request per port.
//
// Ports:
//   clk, reset                      rising-edge clock, asynchronous active-high reset
//   instrmem_rd, pc                 fetch request / address (absolute, program origin BASE_ADDR)
//   Instr_dout, complete_instr      fetched word, valid during the completion pulse
//   Data_rd, Data_wr, Data_addr     data request; rd and wr together act as a plain read
//   Data_din                        write data, captured with the request
//   Data_dout, complete_data        read data, valid during the completion pulse
//   load_en, load_addr, load_data   imem preload strobe (absolute address)
//   mem_err                         sticky error flag
// Build option: define LC3_MEM_OOR_ERR_EN to flag out-of-range fetches/preloads and rd+wr
// conflicts on mem_err, and return 16'hDEAD for out-of-range fetches.
module lc3_mem_responder
    import lc3_mem_pkg::*;
#(
    parameter int                DATA_W     = 16,
    parameter int                ADDR_W     = 16,
    parameter int                IMEM_DEPTH = 256,
    parameter int                DMEM_DEPTH = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(LC3_BASE_ADDR),
    parameter int                IMEM_LAT   = 0,
    parameter int                DMEM_LAT   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instrmem_rd,
    input  logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] Instr_dout,
    output logic              complete_instr,
    input  logic              Data_rd,
    input  logic              Data_wr,
    input  logic [ADDR_W-1:0] Data_addr,
    input  logic [DATA_W-1:0] Data_din,
    output logic [DATA_W-1:0] Data_dout,
    output logic              complete_data,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              mem_err
);

    localparam int                IMEM_AW   = $clog2(IMEM_DEPTH);
    localparam int                DMEM_AW   = $clog2(DMEM_DEPTH);
    localparam logic [ADDR_W-1:0] IMEM_LIM  = ADDR_W'(IMEM_DEPTH);
`ifdef LC3_MEM_OOR_ERR_EN
    localparam logic [DATA_W-1:0] OOR_WORD  = DATA_W'(LC3_OOR_WORD);
`else
    localparam logic [DATA_W-1:0] OOR_WORD  = '0;
`endif

    logic [DATA_W-1:0] r_imem [IMEM_DEPTH];
    logic [DATA_W-1:0] r_dmem [DMEM_DEPTH];

    // ---------------- instruction port ----------------
    logic [ADDR_W-1:0] w_iaddr;
    logic              w_ifire;
    logic              w_iidle;
    logic [ADDR_W-1:0] w_iidx;
    logic              w_ioor;
    logic [ADDR_W-1:0] w_lidx;
    logic              w_loor;
    logic [DATA_W-1:0] r_instr_dout;
    logic              w_unused_iidle;

    lc3_mem_port_fsm #(
        .ADDR_W (ADDR_W),
        .LAT    (IMEM_LAT)
    ) u_ifsm (
        .clk        (clk),
        .reset      (reset),
        .i_req      (instrmem_rd),
        .i_addr     (pc),
        .o_addr     (w_iaddr),
        .o_complete (complete_instr),
        .o_fire     (w_ifire),
        .o_idle     (w_iidle)
    );

    assign w_unused_iidle = w_iidle;

    // Indices are relative to the program origin and wrap mod 2^ADDR_W, so an address
    // below BASE_ADDR lands far above the array and is caught by the range compare.
    assign w_iidx = w_iaddr - BASE_ADDR;
    assign w_ioor = (w_iidx >= IMEM_LIM);
    assign w_lidx = load_addr - BASE_ADDR;
    assign w_loor = (w_lidx >= IMEM_LIM);

    always_ff @(posedge clk) begin
        if (load_en && !w_loor) begin
            r_imem[w_lidx[IMEM_AW-1:0]] <= load_data;
        end
    end

    // Read and preload share an edge; the nonblocking write means a same-edge fetch sees old data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr_dout <= '0;
        end else if (w_ifire) begin
            r_instr_dout <= w_ioor ? OOR_WORD : r_imem[w_iidx[IMEM_AW-1:0]];
        end
    end

    assign Instr_dout = r_instr_dout;

    // ---------------- data port ----------------
    logic              w_dreq;
    logic [ADDR_W-1:0] w_daddr;
    logic              w_dfire;
    logic              w_didle;
    logic              w_dwr_now;
    logic              r_dwr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_data_dout;
    logic              w_unused_dhi;

    assign w_dreq = Data_rd | Data_wr;

    lc3_mem_port_fsm #(
        .ADDR_W (ADDR_W),
        .LAT    (DMEM_LAT)
    ) u_dfsm (
        .clk        (clk),
        .reset      (reset),
        .i_req      (w_dreq),
        .i_addr     (Data_addr),
        .o_addr     (w_daddr),
        .o_complete (complete_data),
        .o_fire     (w_dfire),
        .o_idle     (w_didle)
    );

    // Only the low DMEM_AW bits select a word; higher address bits alias.
    assign w_unused_dhi = ^w_daddr[ADDR_W-1:DMEM_AW];

    // Operation type and write data are frozen when the request is sampled.
    // A read+write request is a read, so it never becomes a write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dwr   <= 1'b0;
            r_wdata <= '0;
        end else if (w_didle && w_dreq) begin
            r_dwr   <= Data_wr & ~Data_rd;
            r_wdata <= Data_din;
        end
    end

    // For a zero-latency port the fire cycle is the sampling cycle, so use the live inputs.
    assign w_dwr_now = w_didle ? (Data_wr & ~Data_rd) : r_dwr;

    // Writes land on the edge closing RESP; an abort or reset never reaches RESP's end.
    always_ff @(posedge clk) begin
        if (complete_data && r_dwr) begin
            r_dmem[w_daddr[DMEM_AW-1:0]] <= r_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_dout <= '0;
        end else if (w_dfire && !w_dwr_now) begin
            r_data_dout <= r_dmem[w_daddr[DMEM_AW-1:0]];
        end
    end

    assign Data_dout = r_data_dout;

    // ---------------- error reporting ----------------
`ifdef LC3_MEM_OOR_ERR_EN
    logic r_mem_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_err <= 1'b0;
        end else if ((w_ifire && w_ioor) || (load_en && w_loor) ||
                     (w_didle && Data_rd && Data_wr)) begin
            r_mem_err <= 1'b1;
        end
    end

    assign mem_err = r_mem_err;
`else
    assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_mem_responder.sv
module tb_lc3_mem_responder;

`ifdef LC3_MEM_OOR_ERR_EN
    localparam logic [15:0] OOR_W  = 16'hDEAD;
    localparam logic        ERR_EN = 1'b1;
`else
    localparam logic [15:0] OOR_W  = 16'h0000;
    localparam logic        ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        instrmem_rd    [2];
    logic [15:0] pc             [2];
    logic [15:0] instr_dout     [2];
    logic        complete_instr [2];
    logic        data_rd        [2];
    logic        data_wr        [2];
    logic [15:0] data_addr      [2];
    logic [15:0] data_din       [2];
    logic [15:0] data_dout      [2];
    logic        complete_data  [2];
    logic        load_en        [2];
    logic [15:0] load_addr      [2];
    logic [15:0] load_data      [2];
    logic        mem_err        [2];

    // Reference model: plain word arrays plus sticky error flag per instance.
    logic [15:0] imem_m [2][256];
    logic [15:0] dmem_m [2][1024];
    logic        err_m  [2];

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Instance 0: default latencies. Instance 1: IMEM_LAT=3, DMEM_LAT=5.
    lc3_mem_responder u_a (
        .clk(clk), .reset(reset),
        .instrmem_rd(instrmem_rd[0]), .pc(pc[0]), .Instr_dout(instr_dout[0]),
        .complete_instr(complete_instr[0]),
        .Data_rd(data_rd[0]), .Data_wr(data_wr[0]), .Data_addr(data_addr[0]),
        .Data_din(data_din[0]), .Data_dout(data_dout[0]), .complete_data(complete_data[0]),
        .load_en(load_en[0]), .load_addr(load_addr[0]), .load_data(load_data[0]),
        .mem_err(mem_err[0])
    );

    lc3_mem_responder #(.IMEM_LAT(3), .DMEM_LAT(5)) u_b (
        .clk(clk), .reset(reset),
        .instrmem_rd(instrmem_rd[1]), .pc(pc[1]), .Instr_dout(instr_dout[1]),
        .complete_instr(complete_instr[1]),
        .Data_rd(data_rd[1]), .Data_wr(data_wr[1]), .Data_addr(data_addr[1]),
        .Data_din(data_din[1]), .Data_dout(data_dout[1]), .complete_data(complete_data[1]),
        .load_en(load_en[1]), .load_addr(load_addr[1]), .load_data(load_data[1]),
        .mem_err(mem_err[1])
    );

    function automatic int ilat(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    function automatic int dlat(input int k);
        return (k == 0) ? 0 : 5;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int k, input logic [15:0] a, input logic [15:0] d);
        logic [15:0] idx;
        idx = a - 16'h3000;
        load_en[k] = 1'b1; load_addr[k] = a; load_data[k] = d;
        @(negedge clk);
        load_en[k] = 1'b0;
        if (idx < 16'd256) imem_m[k][idx[7:0]] = d;
        else err_m[k] = err_m[k] | ERR_EN;
    endtask

    task automatic fetch(input int k, input logic [15:0] a);
        int          n;
        logic [15:0] idx;
        logic [15:0] exp;
        idx = a - 16'h3000;
        exp = (idx < 16'd256) ? imem_m[k][idx[7:0]] : OOR_W;
        instrmem_rd[k] = 1'b1; pc[k] = a;
        n = 0;
        for (int c = 1; c <= 40 && n == 0; c++) begin
            @(negedge clk);
            if (complete_instr[k] === 1'b1) n = c;
            else pc[k] = 16'($urandom);   // must be ignored once sampled
        end
        instrmem_rd[k] = 1'b0;
        if (idx >= 16'd256) err_m[k] = err_m[k] | ERR_EN;
        check($sformatf("fetch_lat[%0d]", k), n, ilat(k) + 1);
        check($sformatf("fetch_dat[%0d] pc=%h", k, a), instr_dout[k], exp);
        @(negedge clk);
        check($sformatf("fetch_width[%0d]", k), complete_instr[k], 1'b0);
        check($sformatf("fetch_err[%0d]", k), mem_err[k], err_m[k]);
    endtask

    task automatic data_op(input int k, input logic rd, input logic wr,
                           input logic [15:0] a, input logic [15:0] d);
        int          n;
        logic [15:0] exp;
        exp = dmem_m[k][a % 1024];
        data_rd[k] = rd; data_wr[k] = wr; data_addr[k] = a; data_din[k] = d;
        n = 0;
        for (int c = 1; c <= 40 && n == 0; c++) begin
            @(negedge clk);
            if (complete_data[k] === 1'b1) n = c;
            else begin
                data_addr[k] = 16'($urandom);
                data_din[k]  = 16'($urandom);
            end
        end
        data_rd[k] = 1'b0; data_wr[k] = 1'b0;
        if (rd && wr) err_m[k] = err_m[k] | ERR_EN;
        check($sformatf("data_lat[%0d]", k), n, dlat(k) + 1);
        if (rd) check($sformatf("data_rd[%0d] a=%h", k, a), data_dout[k], exp);
        else dmem_m[k][a % 1024] = d;
        @(negedge clk);
        check($sformatf("data_width[%0d]", k), complete_data[k], 1'b0);
        check($sformatf("data_err[%0d]", k), mem_err[k], err_m[k]);
    endtask

    initial begin
        int          hits;
        logic [3:0]  pat;
        logic [15:0] w;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            instrmem_rd[k] = 0; pc[k] = 0; data_rd[k] = 0; data_wr[k] = 0;
            data_addr[k] = 0; data_din[k] = 0; load_en[k] = 0; load_addr[k] = 0;
            load_data[k] = 0; err_m[k] = 0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_instr_dout", instr_dout[k], 16'h0);
            check("rst_data_dout", data_dout[k], 16'h0);
            check("rst_cmpl_i", complete_instr[k], 1'b0);
            check("rst_cmpl_d", complete_data[k], 1'b0);
            check("rst_err", mem_err[k], 1'b0);
        end
        reset = 1'b0;
        @(negedge clk);

        // Preload a window at the origin and the last in-range word.
        for (int k = 0; k < 2; k++) begin
            for (int i = 1; i < 16; i++) preload(k, 16'h3000 + 16'(i), 16'($urandom));
            preload(k, 16'h3000, 16'h1261);
            preload(k, 16'h30FF, 16'($urandom));
            for (int s = 0; s < 16; s++) data_op(k, 1'b0, 1'b1, 16'(s), 16'($urandom));
        end

        fetch(0, 16'h3000);                    // 16'h1261, next-cycle completion
        fetch(1, 16'h3000);                    // same word, 3 wait states
        fetch(0, 16'h30FF);
        fetch(1, 16'h30FF);

        // Out-of-range preload must not alias onto word 0.
        preload(0, 16'h3100, 16'h5A5A);
        fetch(0, 16'h3000);
        fetch(0, 16'h3100);
        fetch(0, 16'h2FFF);

        // Preload and fetch of the same word on one edge: fetch sees the old word.
        w = imem_m[0][5];
        instrmem_rd[0] = 1'b1; pc[0] = 16'h3005;
        load_en[0] = 1'b1; load_addr[0] = 16'h3005; load_data[0] = 16'hC0DE;
        @(negedge clk);
        instrmem_rd[0] = 1'b0; load_en[0] = 1'b0;
        imem_m[0][5] = 16'hC0DE;
        check("same_edge_cmpl", complete_instr[0], 1'b1);
        check("same_edge_old", instr_dout[0], w);
        @(negedge clk);
        fetch(0, 16'h3005);

        // Held fetch on the zero-latency port: a new completion every second cycle.
        instrmem_rd[0] = 1'b1; pc[0] = 16'h3001;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            pat[c] = complete_instr[0];
        end
        instrmem_rd[0] = 1'b0;
        check("b2b_pattern", pat, 4'b0101);
        check("b2b_dat", instr_dout[0], imem_m[0][1]);
        @(negedge clk);

        // Alias: write 0x0010, read 0x0410.
        for (int k = 0; k < 2; k++) begin
            data_op(k, 1'b0, 1'b1, 16'h0010, 16'hBEEF);
            data_op(k, 1'b1, 1'b0, 16'h0410, 16'h0);
        end

        // Read+write together is a read only.
        data_op(1, 1'b1, 1'b1, 16'h0003, 16'h7777);
        data_op(1, 1'b1, 1'b0, 16'h0003, 16'h0);

        // Write abandoned during WAIT: no completion, no memory effect.
        data_wr[1] = 1'b1; data_addr[1] = 16'h0007; data_din[1] = 16'h1111;
        hits = 0;
        repeat (2) begin
            @(negedge clk);
            if (complete_data[1] === 1'b1) hits++;
        end
        data_wr[1] = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (complete_data[1] === 1'b1) hits++;
        end
        check("abort_no_cmpl", hits, 0);
        data_op(1, 1'b1, 1'b0, 16'h0007, 16'h0);

        // Randomized mix across both instances.
        for (int it = 0; it < 30; it++) begin
            int k;
            int op;
            logic [15:0] a;
            k  = int'($urandom_range(0, 1));
            op = int'($urandom_range(0, 9));
            a  = 16'(($urandom_range(0, 63) << 10) | $urandom_range(0, 15));
            if (op < 3)       fetch(k, 16'h3000 + 16'($urandom_range(0, 15)));
            else if (op < 6)  data_op(k, 1'b1, 1'b0, a, 16'h0);
            else if (op < 9)  data_op(k, 1'b0, 1'b1, a, 16'($urandom));
            else              data_op(k, 1'b1, 1'b1, a, 16'($urandom));
        end

        // Reset asserted while a write waits: nothing completes, nothing is written.
        data_wr[1] = 1'b1; data_addr[1] = 16'h0009; data_din[1] = 16'h2222;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        err_m[0] = 1'b0; err_m[1] = 1'b0;
        check("rstw_cmpl_d", complete_data[1], 1'b0);
        check("rstw_dout_b", data_dout[1], 16'h0);
        check("rstw_dout_a", data_dout[0], 16'h0);
        check("rstw_instr_a", instr_dout[0], 16'h0);
        check("rstw_err_a", mem_err[0], 1'b0);
        check("rstw_err_b", mem_err[1], 1'b0);
        data_wr[1] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        data_op(1, 1'b1, 1'b0, 16'h0009, 16'h0);
        fetch(1, 16'h3000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
